cen_rate_monitor: RTL

CEN_RATE_MONITOR -- requirements
Module: cen_rate_monitor

---
 rtl/tnkiii_clk_pkg.sv | 24 ++
 rtl/sat_counter.sv | 21 ++
 rtl/cen_rate_monitor.sv | 123 ++++++++++++
 3 files changed

// File: rtl/tnkiii_clk_pkg.sv
// Shared clock-enable definitions: monitor FSM states and per-strobe period limits
// expressed in 53.6 MHz master-clock cycles.
package tnkiii_clk_pkg;

   localparam int unsigned CNT_W = 8;

   // 13.4 MHz, 6.7 MHz and 3.35 MHz are exact divisions; 4 MHz is fractional (13.4 cycles)
   localparam int unsigned CEN13_MIN = 4;
   localparam int unsigned CEN13_MAX = 4;
   localparam int unsigned CEN6_MIN  = 8;
   localparam int unsigned CEN6_MAX  = 8;
   localparam int unsigned CEN3_MIN  = 16;
   localparam int unsigned CEN3_MAX  = 16;
   localparam int unsigned CEN4_MIN  = 13;
   localparam int unsigned CEN4_MAX  = 14;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ARMED    = 2'd1,
      ST_TRACKING = 2'd2,
      ST_LOCKED   = 2'd3
   } mon_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clear wins over increment, and clear+increment restarts at 1.
module sat_counter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LIMIT = 255
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] q
);

   localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

   always_ff @(posedge clk) begin
      if (clr)
         q <= inc ? WIDTH'(1) : '0;
      else if (inc && (q < LIM))
         q <= q + WIDTH'(1);
   end

endmodule

// File: rtl/cen_rate_monitor.sv
// Clock-enable cadence monitor: checks the interval between strobes, declares lock,
// counts violations, and reports strobes per 2^WINDOW_LOG2-cycle window.
module cen_rate_monitor
   import tnkiii_clk_pkg::*;
#(
   parameter int unsigned MIN_PERIOD  = CEN13_MIN,
   parameter int unsigned MAX_PERIOD  = CEN13_MAX,
   parameter int unsigned LOCK_COUNT  = 8,
   parameter int unsigned WINDOW_LOG2 = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_cen,
   output logic                   o_locked,
   output logic                   o_err,
   output logic [CNT_W-1:0]       o_err_cnt,
   output logic [CNT_W-1:0]       o_period,
   output logic [WINDOW_LOG2:0]   o_rate,
   output logic                   o_rate_valid
);

   localparam int unsigned      RW      = WINDOW_LOG2 + 1;
   localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
   localparam logic [CNT_W-1:0] MAX_P   = CNT_W'(MAX_PERIOD);
   localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MAX_PERIOD + 1);
   localparam logic [CNT_W-1:0] LOCK_N  = CNT_W'(LOCK_COUNT);

   mon_state_t             state;
   logic [CNT_W-1:0]       ivl;
   logic [CNT_W-1:0]       good;
   logic [WINDOW_LOG2-1:0] win;
   logic [RW-1:0]          pulses;

   logic pulse, measuring, in_range, good_pulse, bad_pulse, timeout, err_ev;

   // ivl holds the interval a strobe would measure if sampled this cycle
   assign pulse      = i_cen && !i_rst;
   assign measuring  = (state != ST_IDLE);
   assign in_range   = (ivl >= MIN_P) && (ivl <= MAX_P);
   assign good_pulse = measuring && pulse && in_range;
   assign bad_pulse  = measuring && pulse && !in_range;
   assign timeout    = measuring && !pulse && !i_rst && (ivl == TIMEOUT);
   assign err_ev     = bad_pulse || timeout;

   sat_counter #(.WIDTH(CNT_W), .LIMIT(255)) u_ivl (
      .clk (i_clk),
      .clr (i_rst || pulse),
      .inc (!i_rst),
      .q   (ivl)
   );

   sat_counter #(.WIDTH(CNT_W), .LIMIT(LOCK_COUNT)) u_good (
      .clk (i_clk),
      .clr (i_rst || err_ev),
      .inc (good_pulse),
      .q   (good)
   );

   sat_counter #(.WIDTH(CNT_W), .LIMIT(255)) u_err (
      .clk (i_clk),
      .clr (i_rst),
      .inc (err_ev),
      .q   (o_err_cnt)
   );

   // Cadence FSM with registered lock/error/period outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= ST_IDLE;
         o_locked <= 1'b0;
         o_err    <= 1'b0;
         o_period <= '0;
      end else begin
         o_err <= err_ev;
         if (measuring && pulse)
            o_period <= ivl;
         case (state)
            ST_IDLE: begin
               o_locked <= 1'b0;
               if (pulse)
                  state <= ST_ARMED;
            end
            default: begin
               if (timeout) begin
                  state    <= ST_IDLE;
                  o_locked <= 1'b0;
               end else if (bad_pulse) begin
                  state    <= ST_ARMED;
                  o_locked <= 1'b0;
               end else if (good_pulse) begin
                  if (good >= (LOCK_N - CNT_W'(1))) begin
                     state    <= ST_LOCKED;
                     o_locked <= 1'b1;
                  end else begin
                     state    <= ST_TRACKING;
                     o_locked <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   // Free-running rate window; the final cycle's strobe belongs to the closing window
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         win          <= '0;
         pulses       <= '0;
         o_rate       <= '0;
         o_rate_valid <= 1'b0;
      end else begin
         win          <= win + WINDOW_LOG2'(1);
         o_rate_valid <= &win;
         if (&win) begin
            o_rate <= pulses + RW'(i_cen);
            pulses <= '0;
         end else begin
            pulses <= pulses + RW'(i_cen);
         end
      end
   end

endmodule
